// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate cache of one-word lines,
// placed between a single-cycle core's load/store path and a handshaked main memory.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata    core access request (full-word loads and stores)
//   cpu_rdata                load data, valid when cpu_req & ~cpu_we & ~stall
//   stall                    freezes the core while a miss or store is outstanding
//   mem_req/we/addr/wdata    memory transaction, driven only from state and latched registers
//   mem_rdata, mem_ack       memory read data and one-cycle completion pulse
//   hit_count, miss_count    load hit / load miss counters (wrap modulo 2^32)
module data_cache #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SETS       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned TAG_W = DATA_WIDTH - IDX - 2;
  localparam int unsigned WA_W  = DATA_WIDTH - 2;

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  state_e state_q, state_d;

  // Latched word address and store data for the outstanding memory transaction.
  logic [WA_W-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  logic [31:0] hit_q, miss_q;

  logic [IDX-1:0]   req_idx, lat_idx;
  logic [TAG_W-1:0] req_tag, lat_tag;
  logic             req_hit, lat_hit;
  logic             hit_inc, miss_inc, fill_en, upd_en;

  // Byte-offset bits are ignored by a word-only cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign req_idx = cpu_addr[IDX+1:2];
  assign req_tag = cpu_addr[DATA_WIDTH-1:IDX+2];
  assign lat_idx = addr_q[IDX-1:0];
  assign lat_tag = addr_q[WA_W-1:IDX];

  assign req_hit = cpu_req & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign lat_hit = valid_q[lat_idx] & (tag_q[lat_idx] == lat_tag);

  // Memory address/data come straight from the latches, so they hold stable for the
  // whole transaction regardless of what the core does with cpu_*.
  assign mem_addr   = {addr_q, 2'b00};
  assign mem_wdata  = wdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    stall     = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    fill_en   = 1'b0;
    upd_en    = 1'b0;
    case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (cpu_we) begin
            stall   = 1'b1;
            addr_d  = cpu_addr[DATA_WIDTH-1:2];
            wdata_d = cpu_wdata;
            state_d = StWrite;
          end else if (req_hit) begin
            cpu_rdata = data_q[req_idx];
            hit_inc   = 1'b1;
          end else begin
            stall    = 1'b1;
            miss_inc = 1'b1;
            addr_d   = cpu_addr[DATA_WIDTH-1:2];
            state_d  = StFill;
          end
        end
      end
      StFill: begin
        mem_req = 1'b1;
        stall   = ~mem_ack;
        if (mem_ack) begin
          // Forward the fill data to the core in the same cycle it is written.
          cpu_rdata = mem_rdata;
          fill_en   = 1'b1;
          state_d   = StIdle;
        end
      end
      StWrite: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        stall   = ~mem_ack;
        if (mem_ack) begin
          // Write-through without allocate: only refresh a line that already holds it.
          upd_en  = lat_hit;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (hit_inc) hit_q <= hit_q + 32'd1;
      if (miss_inc) miss_q <= miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(SETS); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (fill_en) begin
        valid_q[lat_idx] <= 1'b1;
        tag_q[lat_idx]   <= lat_tag;
        data_q[lat_idx]  <= mem_rdata;
      end
      if (upd_en) begin
        data_q[lat_idx] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
`timescale 1ns/1ps
module tb_data_cache;

  localparam int unsigned DW   = 32;
  localparam int unsigned NSET = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          stall, mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [31:0]   hit_count, miss_count;

  data_cache #(.DATA_WIDTH(DW), .SETS(NSET)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cache contents per set, plus a sparse main memory.
  bit          m_valid [NSET];
  logic [31:0] m_tag   [NSET];
  logic [31:0] m_data  [NSET];
  logic [31:0] mem_model [logic [31:0]];
  int unsigned exp_hits = 0;
  int unsigned exp_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] wa);
    if (mem_model.exists(wa)) return mem_model[wa];
    return wa ^ 32'hA5A5_5A5A;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NSET); i++) m_valid[i] = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
  endtask

  // One core access. k = cycle (1..) after the detect cycle on which memory acks.
  // abort_at > 0 asserts reset in that transaction cycle instead of completing.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int k, input int abort_at);
    logic [31:0] wa;
    logic [31:0] tag;
    logic [31:0] mv;
    int          idx;
    bit          hit;
    wa  = {addr[31:2], 2'b00};
    idx = int'((addr >> 2) % NSET);
    tag = addr >> 5;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    #2;
    if (!we && hit) begin
      check_eq("hit_stall", stall, 0);
      check_eq("hit_rdata", cpu_rdata, m_data[idx]);
      check_eq("hit_mem_req", mem_req, 0);
      exp_hits++;
      return;
    end
    check_eq("detect_stall", stall, 1);
    check_eq("detect_mem_req", mem_req, 0);
    if (!we) exp_miss++;
    mv = mem_read(wa);
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst     = 1'b0;
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        #2;
        check_eq("abort_mem_req", mem_req, 0);
        check_eq("abort_stall", stall, 0);
        check_eq("abort_hits", hit_count, 0);
        check_eq("abort_miss", miss_count, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      mem_ack   = (c == k);
      mem_rdata = (c == k) ? mv : $urandom;
      #2;
      check_eq("xact_mem_req", mem_req, 1);
      check_eq("xact_mem_we", mem_we, we);
      check_eq("xact_mem_addr", mem_addr, wa);
      if (we) check_eq("xact_mem_wdata", mem_wdata, wdata);
      check_eq("xact_stall", stall, (c != k));
      if (c == k && !we) check_eq("fill_rdata", cpu_rdata, mv);
    end
    if (we) begin
      mem_model[wa] = wdata;
      if (hit) m_data[idx] = wdata;
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_data[idx]  = mv;
    end
  endtask

  // Cycle with no request; a stray mem_ack must be ignored.
  task automatic idle_cycle();
    @(negedge clk);
    cpu_req  = 1'b0;
    cpu_addr = $urandom;
    mem_ack  = 1'($urandom_range(0, 1));
    #2;
    check_eq("idle_stall", stall, 0);
    check_eq("idle_mem_req", mem_req, 0);
    check_eq("idle_rdata", cpu_rdata, 0);
    check_eq("idle_hits", hit_count, exp_hits);
    check_eq("idle_miss", miss_count, exp_miss);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    check_eq("rst_stall", stall, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_rdata", cpu_rdata, 0);
    check_eq("rst_hits", hit_count, 0);
    check_eq("rst_miss", miss_count, 0);
    @(negedge clk);
    rst = 1'b1;

    // Cold miss with 3-cycle memory, then a zero-stall hit.
    mem_model[32'h100] = 32'hDEAD_BEEF;
    do_access(1'b0, 32'h100, 32'h0, 3, 0);
    do_access(1'b0, 32'h100, 32'h0, 1, 0);
    idle_cycle();
    check_eq("cold_hits", hit_count, 1);
    check_eq("cold_miss", miss_count, 1);

    // Conflict eviction in set 0.
    do_access(1'b0, 32'h120, 32'h0, 2, 0);
    do_access(1'b0, 32'h100, 32'h0, 2, 0);
    idle_cycle();
    check_eq("conflict_miss", miss_count, 3);

    // Store hit updates the line; single-cycle ack on the fill.
    mem_model[32'h104] = 32'h11;
    do_access(1'b0, 32'h104, 32'h0, 1, 0);
    do_access(1'b1, 32'h104, 32'h22, 2, 0);
    do_access(1'b0, 32'h104, 32'h0, 1, 0);
    idle_cycle();

    // Store miss does not allocate.
    do_access(1'b1, 32'h200, 32'h55, 1, 0);
    do_access(1'b0, 32'h200, 32'h0, 2, 0);
    idle_cycle();

    // Reset in the middle of a fill, then the same load misses again.
    do_access(1'b0, 32'h140, 32'h0, 4, 2);
    do_access(1'b0, 32'h140, 32'h0, 1, 0);
    idle_cycle();
    check_eq("post_abort_miss", miss_count, 1);

    for (int i = 0; i < 400; i++) begin
      bit          we;
      logic [31:0] addr;
      int          k;
      int          ab;
      we   = ($urandom_range(0, 2) == 0);
      addr = $urandom_range(0, 1023);
      k    = $urandom_range(1, 4);
      ab   = (k > 1 && $urandom_range(0, 39) == 0) ? $urandom_range(1, k - 1) : 0;
      do_access(we, addr, $urandom, k, ab);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
